// File: rtl/lock_pkg.sv
// Shared types and helpers for the c499 key loader and the locked-core wrapper.
package lock_pkg;

    localparam int KEY_W_DEF = 24;
    localparam int CHK_W     = 8;
    localparam int MAX_KEY_W = 64;

    // key_out[X_KEY_LSB + i] drives X_{i+1}; key_out[P_KEY_LSB + j] drives p{j+1}
    localparam int X_KEY_LSB = 0;
    localparam int X_KEY_CNT = 20;
    localparam int P_KEY_LSB = 20;
    localparam int P_KEY_CNT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // Callers zero-extend the key, so folding every byte equals folding the real ones.
    function automatic logic [CHK_W-1:0] xor_fold(input logic [MAX_KEY_W-1:0] key);
        logic [CHK_W-1:0] acc;
        acc = {CHK_W{1'b0}};
        for (int b = 0; b < MAX_KEY_W / CHK_W; b++) begin
            acc = acc ^ key[b*CHK_W +: CHK_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/lock_key_shreg.sv
// Frame shift register and bit counter; flags the cycle that carries the last bit.
module lock_key_shreg
    import lock_pkg::*;
#(
    parameter int FRAME_W = KEY_W_DEF + CHK_W
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_shift,
    input  logic               i_bit,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_frame_done
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    logic [FRAME_W-1:0] r_frame;
    logic [CNT_W-1:0]   r_bit_cnt;

    // Shift MSB-first; a clear only rewinds the count since a full frame overwrites every bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame   <= '0;
            r_bit_cnt <= '0;
        end else if (i_clr) begin
            r_bit_cnt <= '0;
        end else if (i_shift) begin
            r_frame   <= {r_frame[FRAME_W-2:0], i_bit};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end else begin
            r_bit_cnt <= r_bit_cnt;
        end
    end

    assign o_frame      = r_frame;
    assign o_frame_done = i_shift & (r_bit_cnt == CNT_W'(FRAME_W - 1));

endmodule

// File: rtl/lock_key_loader.sv
// Serial key loader for the locked c499 core: checksum-validated, atomic key update, lockout.
module lock_key_loader
    import lock_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int MAX_FAIL = 3
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start,
    input  logic             key_valid,
    input  logic             key_bit,
    output logic [KEY_W-1:0] key_out,
    output logic             key_ready,
    output logic             key_err,
    output logic             busy,
    output logic             locked_out
);

    localparam int FRAME_W = KEY_W + CHK_W;

    state_t             r_state;
    logic [3:0]         r_fail_cnt;
    logic [KEY_W-1:0]   r_key_out;
    logic               r_key_ready;
    logic               r_key_err;
    logic               r_busy;
    logic               r_locked_out;

    logic               w_clr;
    logic               w_shift;
    logic               w_frame_done;
    logic [FRAME_W-1:0] w_frame;
    logic [CHK_W-1:0]   w_calc;
    logic               w_chk_ok;
    logic [3:0]         w_fail_nxt;

    // Shifter strobes: start wins over a coincident valid bit
    always_comb begin
        w_clr   = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr   = key_start;
                w_shift = 1'b0;
            end
            SHIFT: begin
                w_clr   = key_start;
                w_shift = key_valid & ~key_start;
            end
            default: begin
                w_clr   = 1'b0;
                w_shift = 1'b0;
            end
        endcase
    end

    lock_key_shreg #(
        .FRAME_W (FRAME_W)
    ) u_shreg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_clr),
        .i_shift      (w_shift),
        .i_bit        (key_bit),
        .o_frame      (w_frame),
        .o_frame_done (w_frame_done)
    );

    assign w_calc     = xor_fold(MAX_KEY_W'(w_frame[FRAME_W-1:CHK_W]));
    assign w_chk_ok   = (w_calc == w_frame[CHK_W-1:0]);
    assign w_fail_nxt = r_fail_cnt + 4'd1;

    // Control FSM with registered outputs; key_out only ever takes a fully checked frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_fail_cnt   <= 4'd0;
            r_key_out    <= '0;
            r_key_ready  <= 1'b0;
            r_key_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (key_start) begin
                        r_state   <= SHIFT;
                        r_busy    <= 1'b1;
                        r_key_err <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (key_start) begin
                        r_key_err <= 1'b0;
                    end else if (w_frame_done) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_busy <= 1'b0;
                    if (w_chk_ok) begin
                        r_key_out   <= w_frame[FRAME_W-1:CHK_W];
                        r_key_ready <= 1'b1;
                        r_fail_cnt  <= 4'd0;
                        r_state     <= IDLE;
                    end else begin
                        r_key_err  <= 1'b1;
                        r_fail_cnt <= w_fail_nxt;
                        if (w_fail_nxt >= 4'(MAX_FAIL)) begin
                            r_state      <= LOCKOUT;
                            r_key_out    <= '0;
                            r_key_ready  <= 1'b0;
                            r_locked_out <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    r_key_out    <= '0;
                    r_key_ready  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_locked_out <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign key_out    = r_key_out;
    assign key_ready  = r_key_ready;
    assign key_err    = r_key_err;
    assign busy       = r_busy;
    assign locked_out = r_locked_out;

endmodule

// File: doc/lock_key_loader.md
# lock_key_loader

Serial key-provisioning stage that sits directly upstream of the locked c499 error-correction core. It receives a key frame bit-serially, checks the frame against an XOR-fold checksum, and drives the core's 20 XOR key inputs (X_1..X_20) and 4 mux-select key inputs (p1..p4) from a registered parallel key. Until a valid frame lands, the core sees an all-zero key. After MAX_FAIL consecutive bad frames, the loader locks out until reset.

## Interface
- KEY_W, default 24: key bits; 20 XOR keys plus 4 mux keys; must be a multiple of 8.
- MAX_FAIL, default 3: consecutive checksum failures that trigger lockout; range 1..15.
- clk  in  1  single clock; rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- key_start  in  1  one-cycle frame start; the first bit may arrive on the next cycle.
- key_valid  in  1  key_bit is valid this cycle.
- key_bit  in  1  serial data; MSB first; KEY_W key bits, then 8 checksum bits.
- key_out  out  KEY_W  applied key; bit i drives X_{i+1} for i<20; bit 20+j drives p{j+1}.
- key_ready  out  1  level; a validated key is held on key_out.
- key_err  out  1  sticky; the last frame failed its checksum; cleared by key_start.
- busy  out  1  high in SHIFT or CHECK.
- locked_out  out  1  lockout reached; held until reset.

## Operation
- States:
  - IDLE: waiting for a frame.
  - SHIFT: taking in bits.
  - CHECK: comparing the checksum (one cycle).
  - LOCKOUT: terminal until reset.
- IDLE -> SHIFT on key_start. key_valid in IDLE is ignored.
- SHIFT:
  - Each cycle with key_valid shifts key_bit into a (KEY_W+8)-bit shift register and increments bit_cnt.
  - When bit_cnt reaches KEY_W+8, the state moves to CHECK.
  - key_start in SHIFT aborts the current frame: bit_cnt is cleared, the state stays SHIFT, key_err clears, and key_out is unchanged.
- CHECK:
  - calc = XOR of the KEY_W/8 key bytes.
  - If calc equals the received checksum: key_out <= key field, key_ready <= 1, fail_cnt <= 0, then IDLE.
  - Otherwise: key_out and key_ready are unchanged, key_err <= 1, and fail_cnt increments.
  - If fail_cnt reaches MAX_FAIL, the state goes to LOCKOUT; otherwise IDLE.
- LOCKOUT:
  - key_out is forced to 0 and key_ready to 0; locked_out = 1.
  - All inputs are ignored.
- A new valid frame replaces key_out atomically. The core never sees a partially shifted key.
- key_start in CHECK is ignored.

## Timing
- Reset values: key_out=0, key_ready=0, key_err=0, busy=0, locked_out=0; state IDLE, bit_cnt=0, fail_cnt=0.
- The last key_valid bit is sampled at edge E. The state is CHECK after E. key_out, key_ready and key_err update at edge E+1.
- Minimum frame duration: 1 start cycle + KEY_W+8 bit cycles + 1 CHECK cycle.
- Gaps in key_valid during SHIFT are allowed with no timeout.
- key_start and key_valid in the same cycle: start takes priority; that bit is discarded.
- Reset mid-SHIFT or in LOCKOUT returns every register to its reset value, including key_out=0.

## Structure
- Package lock_pkg holds:
  - KEY_W default and CHK_W=8.
  - The state enum typedef (IDLE, SHIFT, CHECK, LOCKOUT).
  - A function xor_fold(key) returning the 8-bit checksum.
  - The key_out bit-to-X/p index mapping constants, shared with the locked-core wrapper.
- One sub-module, lock_key_shreg: the shift register plus bit counter, with a frame_done output. The FSM, checksum compare, fail counter and output register stay in lock_key_loader.

## Test plan
- Good frame: key 0xA5C3F0, checksum 0x96 (A5^C3^F0). Required: key_out=0xA5C3F0 and key_ready=1 one edge after CHECK; key_err=0; busy low afterwards.
- Bad checksum: key 0x123456 with checksum 0x00 (correct value 0x00^... = 0x70). Required: key_err=1, key_ready=0, key_out=0. A following good frame 0x123456/0x70 loads it and clears key_err at start.
- Restart: key_start after 10 bits of one frame, then a full good frame 0x0F0F0F/0x0F. Required: key_out=0x0F0F0F; the partial frame leaves no trace.
- Lockout (MAX_FAIL=3): good frame 0xA5C3F0/0x96, then three bad frames. Required: locked_out=1 after the third CHECK, key_out=0, key_ready=0. A further good frame is ignored until rst_n is low for one edge.
- Reset mid-SHIFT: rst_n low after 12 bits. Required: all outputs at reset values on the next edge; a subsequent good frame loads normally.
- Gapped key_valid (random idle cycles) with key_start+key_valid coincident on a first attempt. Required: the coincident bit is dropped and the frame 0xFFFFFF/0xFF loads correctly.
